// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: device-side PS/2 transmitter (synthesizable keyboard model).
// Scan-code bytes are queued through a valid/ready port into a small FIFO and
// sent as 11-bit frames: start(0), 8 data bits LSB first, odd parity, stop(1).
// Optional build macro PS2_KBD_TX_BREAK_EN adds in_break, which enqueues 0xF0
// followed by in_data as one atomic two-entry push.
module ps2_kbd_tx #(
  parameter int CLK_DIV    = 2500,  // sys-clk cycles per ps2_clk half-period, >= 2
  parameter int GAP_CYC    = 5000,  // idle cycles between frames
  parameter int FIFO_DEPTH = 4      // power of 2, >= 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
`ifdef PS2_KBD_TX_BREAK_EN
  input  logic                          in_break,
`endif
  output logic                          in_ready,
  output logic                          ps2_clk,
  output logic                          ps2_data,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int CNTW    = PW + 1;
  localparam int MAX_CYC = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0]   DIV_LOAD = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   GAP_LOAD = CW'(GAP_CYC - 1);
  localparam logic [CNTW-1:0] DEPTH    = CNTW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, BIT_HI, BIT_LO, GAP} state_t;

  state_t          state_reg;
  logic [7:0]      mem_reg [FIFO_DEPTH];
  logic [7:0]      head_reg;
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [CNTW-1:0] cnt_reg;
  logic [CNTW-1:0] cnt_next;
  logic [10:0]     sh_reg;
  logic [3:0]      bit_idx_reg;
  logic [CW-1:0]   tmr_reg;
  logic            ps2_clk_reg;
  logic            ps2_data_reg;
  logic            busy_reg;
  logic            pop;
  logic [1:0]      push_n;

`ifdef PS2_KBD_TX_BREAK_EN
  // Ready only when a two-entry break push would fit, so the rule is uniform.
  assign in_ready = ((DEPTH - cnt_reg) >= CNTW'(2));
  assign push_n   = (in_valid && in_ready) ? (in_break ? 2'd2 : 2'd1) : 2'd0;
`else
  assign in_ready = (cnt_reg != DEPTH);
  assign push_n   = {1'b0, in_valid && in_ready};
`endif

  // The head byte leaves the FIFO on the single LOAD cycle.
  assign pop      = (state_reg == LOAD);
  assign cnt_next = cnt_reg + CNTW'(push_n) - CNTW'(pop);

  assign ps2_clk  = ps2_clk_reg;
  assign ps2_data = ps2_data_reg;
  assign busy     = busy_reg;
  assign fifo_cnt = cnt_reg;

  // FIFO storage with registered head read; a byte written at edge t is
  // visible in head_reg from edge t+1, which is never later than LOAD.
  always_ff @(posedge clk) begin
`ifdef PS2_KBD_TX_BREAK_EN
    if (push_n == 2'd2) begin
      mem_reg[wr_ptr_reg]                <= 8'hF0;
      mem_reg[PW'(wr_ptr_reg + 1'b1)]    <= in_data;
    end else if (push_n == 2'd1) begin
      mem_reg[wr_ptr_reg] <= in_data;
    end
`else
    if (push_n[0]) begin
      mem_reg[wr_ptr_reg] <= in_data;
    end
`endif
    head_reg <= mem_reg[rd_ptr_reg];
  end

  // FIFO pointers and occupancy; pointers wrap naturally at PW bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PW'(push_n);
      rd_ptr_reg <= rd_ptr_reg + PW'(pop);
      cnt_reg    <= cnt_next;
    end
  end

  // Frame FSM: one shared down-counter times both clock phases and the gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      sh_reg       <= '1;
      bit_idx_reg  <= '0;
      tmr_reg      <= '0;
      ps2_clk_reg  <= 1'b1;
      ps2_data_reg <= 1'b1;
      busy_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cnt_reg != '0) begin
            state_reg <= LOAD;
            busy_reg  <= 1'b1;
          end
        end
        LOAD: begin
          sh_reg       <= {1'b1, ~^head_reg, head_reg, 1'b0};
          bit_idx_reg  <= '0;
          tmr_reg      <= DIV_LOAD;
          ps2_clk_reg  <= 1'b1;
          ps2_data_reg <= 1'b0;  // start bit, sh[0]
          state_reg    <= BIT_HI;
        end
        BIT_HI: begin
          if (tmr_reg == '0) begin
            tmr_reg     <= DIV_LOAD;
            ps2_clk_reg <= 1'b0;  // receiver samples on this falling edge
            state_reg   <= BIT_LO;
          end else begin
            tmr_reg <= tmr_reg - 1'b1;
          end
        end
        BIT_LO: begin
          if (tmr_reg == '0) begin
            ps2_clk_reg <= 1'b1;
            if (bit_idx_reg == 4'd10) begin
              tmr_reg      <= GAP_LOAD;
              ps2_data_reg <= 1'b1;
              state_reg    <= GAP;
            end else begin
              tmr_reg      <= DIV_LOAD;
              bit_idx_reg  <= bit_idx_reg + 4'd1;
              ps2_data_reg <= sh_reg[bit_idx_reg + 4'd1];
              state_reg    <= BIT_HI;
            end
          end else begin
            tmr_reg <= tmr_reg - 1'b1;
          end
        end
        GAP: begin
          if (tmr_reg == '0) begin
            // A queued byte loads on the very next cycle; otherwise rest in IDLE.
            if (cnt_reg != '0) begin
              state_reg <= LOAD;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end else begin
            tmr_reg <= tmr_reg - 1'b1;
          end
        end
        default: begin
          state_reg    <= IDLE;
          ps2_clk_reg  <= 1'b1;
          ps2_data_reg <= 1'b1;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed testbench for ps2_kbd_tx with CLK_DIV=4, GAP_CYC=8, FIFO_DEPTH=4.
// Build with PS2_KBD_TX_BREAK_EN defined to also exercise the break push.
module tb_ps2_kbd_tx;

  localparam int CLK_DIV    = 4;
  localparam int GAP_CYC    = 8;
  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
`ifdef PS2_KBD_TX_BREAK_EN
  logic       in_break = 1'b0;
`endif
  logic       in_ready;
  logic       ps2_clk;
  logic       ps2_data;
  logic       busy;
  logic [2:0] fifo_cnt;

  int checks = 0;
  int errors = 0;

  logic   bits_q[$];
  longint fall_t[$];

  always #5 clk = ~clk;

  ps2_kbd_tx #(
    .CLK_DIV   (CLK_DIV),
    .GAP_CYC   (GAP_CYC),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
`ifdef PS2_KBD_TX_BREAK_EN
    .in_break (in_break),
`endif
    .in_ready (in_ready),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .busy     (busy),
    .fifo_cnt (fifo_cnt)
  );

  // Receiver-side view: capture ps2_data at every falling ps2_clk edge.
  always @(negedge ps2_clk) begin
    bits_q.push_back(ps2_data);
    fall_t.push_back($time);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

`ifdef PS2_KBD_TX_BREAK_EN
  task automatic push_brk(input logic [7:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_break = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_break = 1'b0;
  endtask
`endif

  task automatic clear_mon();
    bits_q.delete();
    fall_t.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy == 1'b0 && fifo_cnt == 3'd0) && n < 3000);
    check_val({tag, " idle"}, {busy, fifo_cnt}, 32'h0);
  endtask

  task automatic check_frame(input string tag, input int base, input logic [7:0] exp, input logic exp_par);
    logic [7:0] d;
    if (bits_q.size() < base + 11) begin
      check_val({tag, " nbits"}, bits_q.size(), base + 11);
    end else begin
      for (int i = 0; i < 8; i++) d[i] = bits_q[base + 1 + i];
      check_val({tag, " start"}, bits_q[base], 0);
      check_val({tag, " data"}, d, exp);
      check_val({tag, " par"}, bits_q[base + 9], exp_par);
      check_val({tag, " stop"}, bits_q[base + 10], 1);
    end
  endtask

  initial begin
    int         nb;
    longint     t_push;
    logic [10:0] got11;
    logic [7:0] rx_byte;
    logic [7:0] rx_code;
    logic       rx_brk;
    logic       rx_en;
    logic [7:0] lb_code [3];
    logic       lb_en   [3];

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check_val("rst ps2_clk", ps2_clk, 1);
    check_val("rst ps2_data", ps2_data, 1);
    check_val("rst busy", busy, 0);
    check_val("rst fifo_cnt", fifo_cnt, 0);
    check_val("rst in_ready", in_ready, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ---- single byte 0x1C ----
    clear_mon();
    push(8'h1C);
    t_push = $time;
    check_val("t1 cnt after push", fifo_cnt, 1);
    nb = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy) nb++;
    end
    check_val("t1 busy cycles", nb, 97);
    check_val("t1 nbits", bits_q.size(), 11);
    got11 = '0;
    for (int i = 0; i < 11; i++) if (i < bits_q.size()) got11[i] = bits_q[i];
    check_val("t1 bits", got11, 11'b100_0011_1000);
    if (fall_t.size() >= 11) begin
      check_val("t1 first fall", 32'(fall_t[0] - t_push), 59);
      check_val("t1 fall spacing", 32'(fall_t[1] - fall_t[0]), 80);
      check_val("t1 span", 32'(fall_t[10] - fall_t[0]), 800);
    end
    check_val("t1 cnt end", fifo_cnt, 0);

    // ---- fill FIFO behind an in-flight frame, overflow offer ----
    clear_mon();
    push(8'h01);
    repeat (4) @(posedge clk);
    push(8'hA5);
    push(8'h00);
    push(8'hFF);
    push(8'h12);
    @(negedge clk);
    check_val("t2 cnt full", fifo_cnt, 4);
    check_val("t2 in_ready full", in_ready, 0);
    push(8'h34);
    check_val("t2 cnt after 34", fifo_cnt, 4);
    wait_idle("t2");
    check_val("t2 nbits", bits_q.size(), 55);
    check_frame("t2 f0", 0,  8'h01, 1'b0);
    check_frame("t2 f1", 11, 8'hA5, 1'b1);
    check_frame("t2 f2", 22, 8'h00, 1'b1);
    check_frame("t2 f3", 33, 8'hFF, 1'b1);
    check_frame("t2 f4", 44, 8'h12, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (fall_t.size() > 11 * (k + 1))
        check_val($sformatf("t2 start gap %0d", k),
                  (fall_t[11 * (k + 1)] - fall_t[11 * k]) >= 960, 1);
    end

    // ---- reset during a frame ----
    clear_mon();
    push(8'h55);
    push(8'h66);
    nb = 0;
    do begin
      @(negedge clk);
      nb++;
    end while (bits_q.size() < 5 && nb < 300);
    check_val("t3 five falls", bits_q.size() >= 5, 1);
    check_val("t3 pre clk", ps2_clk, 0);
    check_val("t3 pre data", ps2_data, 0);
    rst = 1'b1;
    #1;
    check_val("t3 clk async", ps2_clk, 1);
    check_val("t3 data async", ps2_data, 1);
    check_val("t3 cnt async", fifo_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check_val("t3 no more falls", bits_q.size(), 5);
    check_val("t3 busy", busy, 0);

    // ---- loopback decode: make, break prefix, break code ----
    clear_mon();
    push(8'h1C);
    push(8'hF0);
    push(8'h1C);
    wait_idle("t4");
    check_frame("t4 f0", 0,  8'h1C, 1'b0);
    check_frame("t4 f1", 11, 8'hF0, 1'b1);
    check_frame("t4 f2", 22, 8'h1C, 1'b0);
    rx_brk  = 1'b0;
    rx_en   = 1'b0;
    rx_code = 8'h00;
    for (int k = 0; k < 3; k++) begin
      rx_byte = 8'h00;
      for (int i = 0; i < 8; i++)
        if (11 * k + 1 + i < bits_q.size()) rx_byte[i] = bits_q[11 * k + 1 + i];
      if (rx_byte == 8'hF0) begin
        rx_brk = 1'b1;
        rx_en  = 1'b0;
      end else begin
        rx_code = rx_byte;
        rx_en   = !rx_brk;
        rx_brk  = 1'b0;
      end
      lb_code[k] = rx_code;
      lb_en[k]   = rx_en;
    end
    check_val("t4 rx code0", lb_code[0], 8'h1C);
    check_val("t4 rx en0", lb_en[0], 1);
    check_val("t4 rx en1", lb_en[1], 0);
    check_val("t4 rx code2", lb_code[2], 8'h1C);
    check_val("t4 rx en2", lb_en[2], 0);

    // ---- push coinciding with the LOAD pop ----
    clear_mon();
    push(8'h11);
    push(8'h22);
    check_val("t6 cnt in load", fifo_cnt, 2);
    check_val("t6 busy in load", busy, 1);
    push(8'h77);
    check_val("t6 cnt after push+pop", fifo_cnt, 2);
    wait_idle("t6");
    check_frame("t6 f0", 0,  8'h11, 1'b1);
    check_frame("t6 f1", 11, 8'h22, 1'b1);
    check_frame("t6 f2", 22, 8'h77, 1'b1);

`ifdef PS2_KBD_TX_BREAK_EN
    // ---- atomic break push needs two free entries ----
    clear_mon();
    push(8'h01);
    repeat (4) @(posedge clk);
    push(8'h21);
    push(8'h22);
    push(8'h23);
    @(negedge clk);
    check_val("t5 cnt3", fifo_cnt, 3);
    check_val("t5 ready at 3", in_ready, 0);
    push_brk(8'h1C);
    check_val("t5 cnt rejected", fifo_cnt, 3);
    nb = 0;
    do begin
      @(negedge clk);
      nb++;
    end while (fifo_cnt != 3'd2 && nb < 400);
    check_val("t5 cnt2", fifo_cnt, 2);
    check_val("t5 ready at 2", in_ready, 1);
    push_brk(8'h1C);
    check_val("t5 cnt after brk", fifo_cnt, 4);
    wait_idle("t5");
    check_val("t5 nbits", bits_q.size(), 66);
    check_frame("t5 f4", 44, 8'hF0, 1'b1);
    check_frame("t5 f5", 55, 8'h1C, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
